// File: rtl/int_to_fp_seq.sv
// rtl/int_to_fp_seq.sv - sequential sign-magnitude integer to normalized float converter
//
// Converts an 8-bit sign-magnitude integer into a 13-bit float
// {sign, exp[3:0], frac[7:0]} whose value is 0.frac x 2^exp. Normalization
// is done by shifting the fraction left one bit per cycle until its MSB is set.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   conversion request, honoured only while ready=1
//   in[7:0]    in   in[7] = sign, in[6:0] = magnitude
//   ready      out  high only in IDLE
//   done_tick  out  one-cycle pulse when fp holds a fresh result
//   fp[12:0]   out  fp[12] = sign, fp[11:8] = exp, fp[7:0] = frac

module int_to_fp_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  in,
    output logic        ready,
    output logic        done_tick,
    output logic [12:0] fp
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        sign_q,  sign_d;
    logic [3:0]  exp_q,   exp_d;
    logic [7:0]  frac_q,  frac_d;
    logic [12:0] fp_q,    fp_d;

    logic        mag_zero;

    // A zero magnitude never normalizes, so it bypasses NORM entirely.
    assign mag_zero = (in[6:0] == 7'd0);

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        frac_d  = frac_q;
        fp_d    = fp_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (mag_zero) begin
                        // -0 and +0 both give the all-zero result.
                        sign_d  = 1'b0;
                        fp_d    = 13'h0000;
                        state_d = DONE;
                    end else begin
                        // 0.{0,m} x 2^8 equals m; normalization keeps the
                        // value while moving the leading one to frac[7].
                        sign_d  = in[7];
                        frac_d  = {1'b0, in[6:0]};
                        exp_d   = 4'd8;
                        state_d = NORM;
                    end
                end
            end

            NORM: begin
                if (frac_q[7]) begin
                    fp_d    = {sign_q, exp_q, frac_q};
                    state_d = DONE;
                end else begin
                    // Magnitude is nonzero, so at most 7 shifts are needed
                    // and exp never drops below 1.
                    frac_d = {frac_q[6:0], 1'b0};
                    exp_d  = exp_q - 4'd1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            exp_q   <= 4'd0;
            frac_q  <= 8'd0;
            fp_q    <= 13'h0000;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            frac_q  <= frac_d;
            fp_q    <= fp_d;
        end
    end

    assign ready     = (state_q == IDLE);
    assign done_tick = (state_q == DONE);
    assign fp        = fp_q;

endmodule

// File: tb/tb_int_to_fp_seq.sv
// tb/tb_int_to_fp_seq.sv - directed and sweep bench for int_to_fp_seq

module tb_int_to_fp_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  in_s;
    logic        ready;
    logic        done_tick;
    logic [12:0] fp;

    int checks = 0;
    int errors = 0;

    int_to_fp_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in        (in_s),
        .ready     (ready),
        .done_tick (done_tick),
        .fp        (fp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  vin;
        logic [12:0] efp;
        int          elat;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one conversion; lat counts edges after the accepting edge (edge 0).
    task automatic run_conv(input logic [7:0] v, output logic [12:0] fpo, output int lat);
        in_s  = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!done_tick && lat < 20) begin
            tick();
            lat++;
        end
        fpo = fp;
    endtask

    task automatic apply_vec(input string name, input logic [7:0] v,
                             input logic [12:0] efp, input int elat);
        logic [12:0] got;
        int          lat;
        run_conv(v, got, lat);
        chk({name, " latency"}, lat, elat);
        chk({name, " fp"}, got, efp);
        chk({name, " ready in done"}, ready, 1'b0);
        tick();
        chk({name, " done one cycle"}, done_tick, 1'b0);
        chk({name, " ready after"}, ready, 1'b1);
        tick();
        chk({name, " fp held"}, fp, efp);
    endtask

    function automatic int bitlen(input logic [6:0] m);
        int b = 0;
        for (int i = 0; i < 7; i++) if (m[i]) b = i + 1;
        return b;
    endfunction

    initial begin
        logic [12:0] got;
        int          lat;
        logic [7:0]  mask;

        vecs[0]  = '{8'h01, 13'h0180, 8};
        vecs[1]  = '{8'hFF, 13'h17FE, 2};
        vecs[2]  = '{8'h85, 13'h13A0, 6};
        vecs[3]  = '{8'h80, 13'h0000, 0};
        vecs[4]  = '{8'h00, 13'h0000, 0};
        vecs[5]  = '{8'h40, 13'h0780, 2};
        vecs[6]  = '{8'h7F, 13'h07FE, 2};
        vecs[7]  = '{8'hC3, 13'h1786, 2};
        vecs[8]  = '{8'h0A, 13'h04A0, 5};
        vecs[9]  = '{8'h81, 13'h1180, 8};
        vecs[10] = '{8'h13, 13'h0598, 4};

        rst   = 1'b1;
        start = 1'b0;
        in_s  = 8'h00;
        tick();
        tick();
        chk("reset ready", ready, 1'b1);
        chk("reset done", done_tick, 1'b0);
        chk("reset fp", fp, 13'h0000);
        rst = 1'b0;

        // First start right after reset release is accepted on the next edge.
        for (int i = 0; i < 11; i++)
            apply_vec($sformatf("vec%0d_%02h", i, vecs[i].vin), vecs[i].vin,
                      vecs[i].efp, vecs[i].elat);

        // Start pulses while busy and input changes mid-NORM are ignored.
        in_s  = 8'h01;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        in_s  = 8'h7F;
        start = 1'b1;
        tick();
        in_s  = 8'hC0;
        tick();
        start = 1'b0;
        lat = 3;
        while (!done_tick && lat < 20) begin
            tick();
            lat++;
        end
        chk("busy latency", lat, 8);
        chk("busy fp", fp, 13'h0180);
        tick();
        tick();
        chk("busy start not queued", ready, 1'b1);
        chk("busy no extra done", done_tick, 1'b0);

        // Reset mid-NORM aborts with no done_tick and clears fp.
        in_s  = 8'h01;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort done", done_tick, 1'b0);
        chk("abort fp", fp, 13'h0000);
        chk("abort ready", ready, 1'b1);
        mask = 8'h00;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done_tick) mask[i] = 1'b1;
        end
        chk("abort no later done", mask, 8'h00);

        // Reset wins over a simultaneous start.
        rst   = 1'b1;
        start = 1'b1;
        in_s  = 8'hFF;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        chk("rst priority ready", ready, 1'b1);
        tick();
        chk("rst priority idle", ready, 1'b1);
        apply_vec("post_rst_FF", 8'hFF, 13'h17FE, 2);

        // Held start restarts on the first IDLE cycle after DONE.
        in_s  = 8'hFF;
        start = 1'b1;
        mask  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done_tick) mask[i] = 1'b1;
        end
        start = 1'b0;
        chk("held start done edges", mask, 8'h44);
        tick();
        tick();
        chk("held start fp", fp, 13'h17FE);

        // Sweep all inputs against a bit-length model plus round trip.
        for (int v = 0; v < 256; v++) begin
            logic [7:0]  vi;
            logic [6:0]  m;
            logic [12:0] efp;
            logic [7:0]  rt;
            logic [7:0]  ein;
            int          bl;
            vi = v[7:0];
            m  = vi[6:0];
            bl = bitlen(m);
            if (m == 7'd0) efp = 13'h0000;
            else efp = {vi[7], 4'(bl), 8'({1'b0, m} << (8 - bl))};
            run_conv(vi, got, lat);
            chk($sformatf("sweep %02h latency", vi), lat, (m == 0) ? 0 : (9 - bl));
            chk($sformatf("sweep %02h fp", vi), got, efp);
            if (m != 7'd0) begin
                chk($sformatf("sweep %02h norm", vi), got[7], 1'b1);
                chk($sformatf("sweep %02h exp", vi), got[11:8], 4'(bl));
            end
            rt  = {got[12], 7'(got[7:0] >> (8 - int'(got[11:8])))};
            ein = (m == 7'd0) ? 8'h00 : vi;
            chk($sformatf("sweep %02h roundtrip", vi), rt, ein);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
